// File: rtl/mem_ls_unit_if.sv
// -----------------------------------------------------------------------------
// mem_ls_unit_if
//   Byte-wide request/ready memory port between the MEM-stage load/store
//   engine (master) and the data memory (slave). One byte moves per accepted
//   request; a request completes in the cycle where mem_ready_i is high.
//
//   Signals
//     mem_req_o    master -> slave  byte request valid
//     mem_we_o     master -> slave  1 = write byte, 0 = read byte
//     mem_addr_o   master -> slave  byte address
//     mem_wdata_o  master -> slave  byte to write
//     mem_rdata_i  slave  -> master read byte, valid with mem_ready_i
//     mem_ready_i  slave  -> master current request completes this cycle
// -----------------------------------------------------------------------------
interface mem_ls_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mem_ls_unit.sv
// -----------------------------------------------------------------------------
// mem_ls_unit
//   MEM-stage load/store engine. Takes the EX/MEM register contents, performs
//   loads and stores one byte at a time over a request/ready port, assembles
//   and extends load data, and registers the write-back for WB. Upstream is
//   stalled while a multi-byte access is in flight.
//
//   Optional feature (macro MEM_MISALIGN_TRAP_EN):
//     adds misalign_o; misaligned H/HU/SH and W/SW accesses skip the memory
//     and complete in one cycle with misalign_o pulsed. Without the macro
//     misaligned accesses simply proceed byte by byte.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     mem             byte memory port (mem_ls_unit_if.master)
//     valid_i         EX/MEM register holds a valid instruction
//     aluop_i         operation code (EX_*_OP encodings)
//     mem_addr_i      effective address
//     w_data_i        ALU result, or store data for stores
//     w_enable_i      register write requested
//     w_addr_i        destination register
//     w_enable_o      write-back enable
//     w_addr_o        write-back register
//     w_data_o        write-back data
//     stall_req_o     hold upstream stages
//     misalign_o      misaligned access flag (only with MEM_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
module mem_ls_unit #(
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_ls_unit_if.master      mem,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        w_data_i,
  input  logic               w_enable_i,
  input  logic [4:0]         w_addr_i,
  output logic               w_enable_o,
  output logic [4:0]         w_addr_o,
  output logic [31:0]        w_data_o,
  output logic               stall_req_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               misalign_o
`endif
);

  // Operation encodings, mirroring ALUInstDef.vh.
  localparam logic [ALUOP_W-1:0] EX_LB_OP  = ALUOP_W'(8'h10);
  localparam logic [ALUOP_W-1:0] EX_LH_OP  = ALUOP_W'(8'h11);
  localparam logic [ALUOP_W-1:0] EX_LW_OP  = ALUOP_W'(8'h12);
  localparam logic [ALUOP_W-1:0] EX_LBU_OP = ALUOP_W'(8'h13);
  localparam logic [ALUOP_W-1:0] EX_LHU_OP = ALUOP_W'(8'h14);
  localparam logic [ALUOP_W-1:0] EX_SB_OP  = ALUOP_W'(8'h18);
  localparam logic [ALUOP_W-1:0] EX_SH_OP  = ALUOP_W'(8'h19);
  localparam logic [ALUOP_W-1:0] EX_SW_OP  = ALUOP_W'(8'h1A);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Decoded view of an operation; 'last' is the index of the final byte (N-1).
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       sext;
    logic [1:0] last;
  } op_info_t;

  function automatic op_info_t decode(input logic [ALUOP_W-1:0] op);
    op_info_t info;
    info = '0;
    case (op)
      EX_LB_OP:  begin info.is_load  = 1'b1; info.sext = 1'b1; info.last = 2'd0; end
      EX_LBU_OP: begin info.is_load  = 1'b1;                   info.last = 2'd0; end
      EX_LH_OP:  begin info.is_load  = 1'b1; info.sext = 1'b1; info.last = 2'd1; end
      EX_LHU_OP: begin info.is_load  = 1'b1;                   info.last = 2'd1; end
      EX_LW_OP:  begin info.is_load  = 1'b1;                   info.last = 2'd3; end
      EX_SB_OP:  begin info.is_store = 1'b1;                   info.last = 2'd0; end
      EX_SH_OP:  begin info.is_store = 1'b1;                   info.last = 2'd1; end
      EX_SW_OP:  begin info.is_store = 1'b1;                   info.last = 2'd3; end
      default:   info = '0;
    endcase
    return info;
  endfunction

  logic [1:0]  state;
  logic [1:0]  idx;
  op_info_t    info_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic [4:0]  waddr_q;
  logic [31:0] asm_q;

  op_info_t    in_info;
  logic        in_mem;
  logic        busy;
  logic [31:0] asm_next;
  logic [31:0] load_ext;

  assign in_info = decode(aluop_i);
  assign in_mem  = in_info.is_load | in_info.is_store;
  assign busy    = (state == BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
  logic in_misaligned;
  assign in_misaligned = ((in_info.last == 2'd1) && mem_addr_i[0]) ||
                         ((in_info.last == 2'd3) && (mem_addr_i[1:0] != 2'b00));
`endif

  // Stall covers the launch cycle (combinational on the incoming op) and
  // every BUSY cycle; DONE releases upstream so it advances on that edge.
  assign stall_req_o = busy || ((state == IDLE) && valid_i && in_mem);

  // Request fields come straight from latched copies, so they stay stable
  // across wait cycles; outside BUSY the port is driven to zero.
  assign mem.mem_req_o   = busy;
  assign mem.mem_we_o    = busy && info_q.is_store;
  assign mem.mem_addr_o  = busy ? (base_q + {30'd0, idx}) : 32'd0;
  assign mem.mem_wdata_o = busy ? data_q[{idx, 3'b000} +: 8] : 8'd0;

  // Assembly with the byte arriving this cycle merged in, so the final byte
  // and the write-back can be registered on the same edge.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    asm_next = asm_q;
    asm_next[{idx, 3'b000} +: 8] = mem.mem_rdata_i;
    load_ext = asm_next;
    case (info_q.last)
      2'd0:    load_ext = {{24{info_q.sext & asm_next[7]}},  asm_next[7:0]};
      2'd1:    load_ext = {{16{info_q.sext & asm_next[15]}}, asm_next[15:0]};
      default: load_ext = asm_next;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      info_q     <= '0;
      base_q     <= 32'd0;
      data_q     <= 32'd0;
      waddr_q    <= 5'd0;
      asm_q      <= 32'd0;
      w_enable_o <= 1'b0;
      w_addr_o   <= 5'd0;
      w_data_o   <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid_i && in_mem) begin
            info_q     <= in_info;
            base_q     <= mem_addr_i;
            data_q     <= w_data_i;
            waddr_q    <= w_addr_i;
            idx        <= 2'd0;
            asm_q      <= 32'd0;
            w_enable_o <= 1'b0;
            w_addr_o   <= w_addr_i;
`ifdef MEM_MISALIGN_TRAP_EN
            if (in_misaligned) begin
              // No memory traffic: report the fault in the DONE cycle.
              state      <= DONE;
              w_data_o   <= 32'd0;
              misalign_o <= 1'b1;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end else if (valid_i) begin
            w_enable_o <= w_enable_i && (w_addr_i != 5'd0);
            w_addr_o   <= w_addr_i;
            w_data_o   <= w_data_i;
          end else begin
            w_enable_o <= 1'b0;
          end
        end

        BUSY: begin
          if (mem.mem_ready_i) begin
            asm_q <= asm_next;
            if (idx == info_q.last) begin
              state    <= DONE;
              w_addr_o <= waddr_q;
              // Stores and loads to x0 produce no write-back.
              if (info_q.is_load && (waddr_q != 5'd0)) begin
                w_enable_o <= 1'b1;
                w_data_o   <= load_ext;
              end else begin
                w_enable_o <= 1'b0;
                w_data_o   <= 32'd0;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        DONE: begin
          // Write-back is visible for exactly one cycle; valid_i is ignored.
          state      <= IDLE;
          w_enable_o <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ls_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_ls_unit
//   Directed bench for mem_ls_unit. A byte memory model answers requests with
//   a configurable number of wait cycles and records every request cycle; each
//   access is checked for stall length, bus addresses/data and write-back.
// -----------------------------------------------------------------------------
module tb_mem_ls_unit;

  localparam logic [7:0] EX_ADD_OP = 8'h01;
  localparam logic [7:0] EX_LB_OP  = 8'h10;
  localparam logic [7:0] EX_LH_OP  = 8'h11;
  localparam logic [7:0] EX_LW_OP  = 8'h12;
  localparam logic [7:0] EX_LBU_OP = 8'h13;
  localparam logic [7:0] EX_LHU_OP = 8'h14;
  localparam logic [7:0] EX_SB_OP  = 8'h18;
  localparam logic [7:0] EX_SH_OP  = 8'h19;
  localparam logic [7:0] EX_SW_OP  = 8'h1A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  aluop_i = 8'h00;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] w_data_i = 32'd0;
  logic        w_enable_i = 1'b0;
  logic [4:0]  w_addr_i = 5'd0;
  logic        w_enable_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        stall_req_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_ls_unit_if mem_if ();

  mem_ls_unit #(.ALUOP_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mem_if),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .w_data_i    (w_data_i),
    .w_enable_i  (w_enable_i),
    .w_addr_i    (w_addr_i),
    .w_enable_o  (w_enable_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .stall_req_o (stall_req_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

  logic [7:0] mem [bit [31:0]];
  req_t       log_q[$];
  int         wait_cfg = 0;
  int         wcnt = 0;

  initial begin
    mem_if.mem_ready_i = 1'b1;
    mem_if.mem_rdata_i = 8'hA5;
  end

  // Ready is driven high while idle so a stray ready is seen to be ignored.
  always @(negedge clk) begin
    if (mem_if.mem_req_o === 1'b1) begin
      log_q.push_back('{addr: mem_if.mem_addr_o, we: mem_if.mem_we_o, wdata: mem_if.mem_wdata_o});
      if (wcnt < wait_cfg) begin
        mem_if.mem_ready_i = 1'b0;
        mem_if.mem_rdata_i = 8'hA5;
        wcnt++;
      end else begin
        mem_if.mem_ready_i = 1'b1;
        mem_if.mem_rdata_i = mem.exists(mem_if.mem_addr_o) ? mem[mem_if.mem_addr_o] : 8'h00;
        if (mem_if.mem_we_o) mem[mem_if.mem_addr_o] = mem_if.mem_wdata_o;
        wcnt = 0;
      end
    end else begin
      mem_if.mem_ready_i = 1'b1;
      mem_if.mem_rdata_i = 8'hA5;
      wcnt = 0;
    end
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // ---------------- one complete memory access ----------------
  task automatic access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] waddr, input int nbytes,
                        input int wait_n, input logic exp_we, input logic exp_wen,
                        input logic [31:0] exp_data, input logic exp_mis);
    int  cyc;
    bit  done;
    wait_cfg = wait_n;
    log_q.delete();
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; w_data_i = data;
    w_addr_i = waddr; w_enable_i = 1'b1;
    #1 check({tag, " launch stall"}, 32'(stall_req_o), 32'd1);
    cyc = 0;
    done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (stall_req_o) begin
        if (cyc == 0) check({tag, " wen while busy"}, 32'(w_enable_o), 32'd0);
        cyc++;
        // Unrelated op presented while busy must be ignored.
        valid_i = 1'b1; aluop_i = EX_ADD_OP; w_addr_i = 5'd7; w_data_i = 32'hBAD0BAD0;
      end else begin
        done = 1;
        valid_i = 1'b0;
      end
    end
    if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
    check({tag, " stall cycles"}, 32'(cyc), 32'(nbytes * (wait_n + 1)));
    check({tag, " done wen"}, 32'(w_enable_o), 32'(exp_wen));
    check({tag, " done wdata"}, w_data_o, exp_data);
    if (exp_wen) check({tag, " done waddr"}, 32'(w_addr_o), 32'(waddr));
    check({tag, " done req"}, 32'(mem_if.mem_req_o), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, " misalign"}, 32'(misalign_o), 32'(exp_mis));
`else
    if (exp_mis) check({tag, " misalign expected"}, 32'd0, 32'd1);
`endif
    check({tag, " req count"}, 32'(log_q.size()), 32'(nbytes * (wait_n + 1)));
    for (int j = 0; j < log_q.size(); j++) begin
      int k;
      k = j / (wait_n + 1);
      check($sformatf("%s addr[%0d]", tag, j), log_q[j].addr, addr + 32'(k));
      check($sformatf("%s we[%0d]", tag, j), 32'(log_q[j].we), 32'(exp_we));
      if (exp_we) check($sformatf("%s wdata[%0d]", tag, j), 32'(log_q[j].wdata), 32'(data[8*k +: 8]));
    end
    @(negedge clk);
    check({tag, " wen one cycle"}, 32'(w_enable_o), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, " misalign one cycle"}, 32'(misalign_o), 32'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h104] = 8'h55; mem[32'h105] = 8'h66;
    mem[32'h200] = 8'h80;
    mem[32'h300] = 8'h34; mem[32'h301] = 8'h92;
    mem[32'h400] = 8'hC3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst wen",   32'(w_enable_o), 32'd0);
    check("rst waddr", 32'(w_addr_o), 32'd0);
    check("rst wdata", w_data_o, 32'd0);
    check("rst stall", 32'(stall_req_o), 32'd0);
    check("rst req",   32'(mem_if.mem_req_o), 32'd0);
    check("rst we",    32'(mem_if.mem_we_o), 32'd0);
    check("rst addr",  mem_if.mem_addr_o, 32'd0);
    check("rst wbyte", 32'(mem_if.mem_wdata_o), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("rst misalign", 32'(misalign_o), 32'd0);
`endif
    rst_n = 1'b1;

    // Non-memory op: one-cycle latency, x0 suppresses the write
    @(negedge clk);
    valid_i = 1'b1; aluop_i = EX_ADD_OP; w_data_i = 32'h1234; w_addr_i = 5'd3; w_enable_i = 1'b1;
    #1 check("add stall", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    check("add wen",   32'(w_enable_o), 32'd1);
    check("add waddr", 32'(w_addr_o), 32'd3);
    check("add wdata", w_data_o, 32'h1234);
    w_addr_i = 5'd0;
    #1 check("add x0 stall", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    check("add x0 wen", 32'(w_enable_o), 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    check("idle wen", 32'(w_enable_o), 32'd0);

    // Loads
    access("lw",  EX_LW_OP,  32'h100, 32'h0, 5'd5, 4, 0, 1'b0, 1'b1, 32'h44332211, 1'b0);
    access("lb",  EX_LB_OP,  32'h200, 32'h0, 5'd6, 1, 0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
    access("lbu", EX_LBU_OP, 32'h200, 32'h0, 5'd6, 1, 0, 1'b0, 1'b1, 32'h00000080, 1'b0);
    access("lh",  EX_LH_OP,  32'h300, 32'h0, 5'd9, 2, 1, 1'b0, 1'b1, 32'hFFFF9234, 1'b0);
    access("lhu", EX_LHU_OP, 32'h300, 32'h0, 5'd9, 2, 0, 1'b0, 1'b1, 32'h00009234, 1'b0);
    access("lw x0", EX_LW_OP, 32'h100, 32'h0, 5'd0, 4, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Stores, including address wrap and wait states
    access("sw wrap", EX_SW_OP, 32'hFFFFFFFE, 32'hDEADBEEF, 5'd4, 4, 2, 1'b1, 1'b0, 32'h0, 1'b0);
    check("sw mem fffffffe", 32'(rd(32'hFFFFFFFE)), 32'hEF);
    check("sw mem ffffffff", 32'(rd(32'hFFFFFFFF)), 32'hBE);
    check("sw mem 0",        32'(rd(32'h0)),        32'hAD);
    check("sw mem 1",        32'(rd(32'h1)),        32'hDE);
    access("sb", EX_SB_OP, 32'h500, 32'h123456AB, 5'd4, 1, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("sb mem", 32'(rd(32'h500)), 32'hAB);
    access("sh", EX_SH_OP, 32'h600, 32'h1234CDEF, 5'd4, 2, 1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("sh mem 600", 32'(rd(32'h600)), 32'hEF);
    check("sh mem 601", 32'(rd(32'h601)), 32'hCD);

    // Misaligned word
`ifdef MEM_MISALIGN_TRAP_EN
    access("lw mis", EX_LW_OP, 32'h102, 32'h0, 5'd5, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1);
`else
    access("lw mis", EX_LW_OP, 32'h102, 32'h0, 5'd5, 4, 0, 1'b0, 1'b1, 32'h66554433, 1'b0);
`endif

    // Reset in the middle of a word load, after two bytes
    wait_cfg = 0;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = EX_LW_OP; mem_addr_i = 32'h100; w_addr_i = 5'd5;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid req before rst", 32'(mem_if.mem_req_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst req",   32'(mem_if.mem_req_o), 32'd0);
    check("mid rst stall", 32'(stall_req_o), 32'd0);
    check("mid rst wen",   32'(w_enable_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access("lbu after rst", EX_LBU_OP, 32'h400, 32'h0, 5'd8, 1, 0, 1'b0, 1'b1, 32'h000000C3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Hard time limit in case the DUT or bench deadlocks.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_ls_unit.md
Name: mem_ls_unit

Overview:
- MEM-stage load/store engine. Consumes the EX outputs (aluop, effective address, store data, write-back target) and executes loads/stores over a byte-wide request/ready memory port.
- Assembles and extends load data, and produces the registered write-back for the WB stage.
- Requests a pipeline stall while a multi-byte access is in flight.

Parameters:
- ALUOP_W, 8, width of aluop_i; encodings are the EX_*_OP defines from ALUInstDef.vh.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  EX/MEM register holds a valid instruction
- aluop_i  input  ALUOP_W  operation (EX_LB/LH/LW/LBU/LHU/SB/SH/SW_OP or other)
- mem_addr_i  input  32  effective address
- w_data_i  input  32  ALU result, or store data for stores
- w_enable_i  input  1  register write requested
- w_addr_i  input  5  destination register
- w_enable_o  output  1  write-back enable
- w_addr_o  output  5  write-back register
- w_data_o  output  32  write-back data
- stall_req_o  output  1  hold upstream stages
- mem_req_o  output  1  byte request valid
- mem_we_o  output  1  1 = write byte, 0 = read byte
- mem_addr_o  output  32  byte address
- mem_wdata_o  output  8  byte to write
- mem_rdata_i  input  8  read byte, valid with mem_ready_i
- mem_ready_i  input  1  current byte request completes this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0. All outputs 0: w_enable_o, w_addr_o, w_data_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o. stall_req_o=0. Reset mid-access drops mem_req_o immediately and discards any partially assembled data.
- States: IDLE, BUSY, DONE.
- IDLE, valid_i=1, non-memory op: at the next edge, register w_enable_o = w_enable_i && (w_addr_i != 0), w_addr_o, w_data_o = w_data_i. One-cycle latency, no stall.
- IDLE, valid_i=1, memory op:
  - stall_req_o=1 combinationally.
  - At the edge: latch op, address, data, and w_addr. Set idx=0, mem_req_o=1, state=BUSY. w_enable_o=0.
- IDLE, valid_i=0: w_enable_o=0 at the next edge.
- BUSY:
  - stall_req_o=1.
  - mem_addr_o = base + idx, wrapping modulo 2^32.
  - mem_we_o = 1 for stores.
  - mem_wdata_o = store byte idx (little-endian: bits [8*idx+7:8*idx]).
  - Byte count N = 1 (B/BU), 2 (H/HU), 4 (W).
  - Edge with mem_ready_i=1: load byte goes into assembly lane idx. If idx == N-1, go to DONE and mem_req_o=0; otherwise idx++.
  - Request fields are held stable while mem_ready_i=0; no timeout.
- DONE:
  - stall_req_o=0 (upstream advances at this edge).
  - w_enable_o/w_addr_o/w_data_o are valid for exactly this one cycle.
  - Loads: w_enable_o = (w_addr != 0). Stores: w_enable_o=0, w_data_o=0.
  - valid_i is ignored. Next state is IDLE unconditionally.
- Extension: LB sign-extends bit 7; LH sign-extends bit 15; LBU/LHU zero-extend; LW as assembled.
- Load to x0: memory access is still performed; w_enable_o=0, w_data_o=0.
- mem_ready_i while mem_req_o=0: ignored.
- valid_i/op changes while BUSY: ignored; latched copies are used.
- Latency for an N-byte access with ready every cycle: request cycles N, then 1 DONE cycle. Write-back appears N+1 cycles after the launch edge.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - An H/HU/SH access with addr[0]≠0, or a W/SW access with addr[1:0]≠0, issues no memory request. It goes IDLE→DONE in one edge with w_enable_o=0, w_data_o=0, and misalign_o=1 for the DONE cycle only.
- Undefined: misaligned accesses proceed byte-sequentially as above; port absent.

Test Plan:
- LW at 0x100, memory bytes 0x11,0x22,0x33,0x44, ready every cycle, w_addr=5 -> mem_addr_o 0x100..0x103 on 4 consecutive cycles. DONE cycle shows w_enable_o=1, w_addr_o=5, w_data_o=0x44332211. stall_req_o high for 5 cycles (launch + 4 BUSY), low in DONE.
- LB and LBU at 0x200 reading 0x80 -> LB w_data_o=0xFFFFFF80; LBU w_data_o=0x00000080. LH reading 0x34,0x92 -> 0xFFFF9234.
- SW at 0xFFFFFFFE, data 0xDEADBEEF, mem_ready_i low 2 cycles before each byte -> writes EF@0xFFFFFFFE, BE@0xFFFFFFFF, AD@0x0, DE@0x1 (wrap). Request held stable during waits; w_enable_o=0 in DONE.
- ADD result 0x1234, w_addr=3, followed next cycle by the same with w_addr=0 -> w_enable_o=1/data 0x1234 one cycle later, then w_enable_o=0. stall_req_o never asserted.
- rst_n pulsed low mid-LW after 2 bytes -> mem_req_o and stall_req_o drop immediately. After release, state IDLE; a new LBU completes correctly with no stale bytes.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no mem_req_o; next cycle misalign_o=1, w_enable_o=0. Without it -> four byte reads 0x102..0x105.
